// File: rtl/pad_ctrl_sequencer.sv
// pad_ctrl_sequencer: sequences pad IE/OE/DS changes, inserting a turnaround
// gap with both enables low whenever the pad swaps between input and output.
module pad_ctrl_sequencer #(
    parameter int unsigned TURNAROUND_CYCLES = 2,
    parameter int unsigned DS_WIDTH          = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_dir_i,
    input  logic [DS_WIDTH-1:0] req_ds_i,
    input  logic                tx_data_i,
    output logic                rx_data_o,
    output logic                pad_ie_o,
    output logic                pad_oe_o,
    output logic [DS_WIDTH-1:0] pad_ds_o,
    output logic                pad_i_o,
    input  logic                pad_o_i,
    output logic                busy_o,
    output logic [1:0]          mode_o
);

    localparam bit         USE_TURN  = (TURNAROUND_CYCLES != 0);
    localparam logic [3:0] TURN_LOAD = USE_TURN ? 4'(TURNAROUND_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_HIZ    = 2'd0,
        ST_INPUT  = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     target;
    state_t     req_tgt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       sync1;

    // Externally visible mode encoding of a settled state.
    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            ST_INPUT:  mode_of = 2'b01;
            ST_OUTPUT: mode_of = 2'b10;
            default:   mode_of = 2'b00;
        endcase
    endfunction

    assign accept = req_valid_i & req_ready_o;

    // Decode the requested direction; the reserved code falls back to HIZ.
    always_comb begin
        req_tgt = ST_HIZ;
        case (req_dir_i)
            2'b01:   req_tgt = ST_INPUT;
            2'b10:   req_tgt = ST_OUTPUT;
            default: req_tgt = ST_HIZ;
        endcase
    end

    // Next state and turnaround counter; only INPUT<->OUTPUT swaps go through TURN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_TURN: begin
                if (cnt == 4'd0) begin
                    state_nxt = target;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                if (accept && (req_tgt != state)) begin
                    if (USE_TURN && (state != ST_HIZ) && (req_tgt != ST_HIZ)) begin
                        state_nxt = ST_TURN;
                        cnt_nxt   = TURN_LOAD;
                    end else begin
                        state_nxt = req_tgt;
                    end
                end
            end
        endcase
    end

    // State, request capture and registered pad controls derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_HIZ;
            target      <= ST_HIZ;
            cnt         <= 4'd0;
            pad_ie_o    <= 1'b0;
            pad_oe_o    <= 1'b0;
            pad_ds_o    <= '0;
            pad_i_o     <= 1'b0;
            busy_o      <= 1'b0;
            mode_o      <= 2'b00;
            req_ready_o <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                target   <= req_tgt;
                pad_ds_o <= req_ds_i;
                mode_o   <= mode_of(req_tgt);
            end
            pad_ie_o    <= (state_nxt == ST_INPUT);
            pad_oe_o    <= (state_nxt == ST_OUTPUT);
            pad_i_o     <= (state_nxt == ST_OUTPUT) & tx_data_i;
            busy_o      <= (state_nxt == ST_TURN);
            req_ready_o <= (state_nxt != ST_TURN);
        end
    end

    // Two-flop synchronizer for the pad receive data, independent of mode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1     <= 1'b0;
            rx_data_o <= 1'b0;
        end else begin
            sync1     <= pad_o_i;
            rx_data_o <= sync1;
        end
    end

endmodule

// File: tb/tb_pad_ctrl_sequencer.sv
// Bench for pad_ctrl_sequencer: per-cycle expected pad state is queued when
// stimulus is applied and compared after the following rising edge.
module tb_pad_ctrl_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dir;
    logic [2:0] req_ds;
    logic       tx_data;
    logic       rx_data;
    logic       pad_ie;
    logic       pad_oe;
    logic [2:0] pad_ds;
    logic       pad_i;
    logic       pad_o;
    logic       busy;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic       ie;
        logic       oe;
        logic [2:0] ds;
        logic       rdy;
        logic       busy;
        logic [1:0] mode;
        logic       pi;
        logic       rx;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pad_ctrl_sequencer #(
        .TURNAROUND_CYCLES (2),
        .DS_WIDTH          (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_dir_i   (req_dir),
        .req_ds_i    (req_ds),
        .tx_data_i   (tx_data),
        .rx_data_o   (rx_data),
        .pad_ie_o    (pad_ie),
        .pad_oe_o    (pad_oe),
        .pad_ds_o    (pad_ds),
        .pad_i_o     (pad_i),
        .pad_o_i     (pad_o),
        .busy_o      (busy),
        .mode_o      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ie, input logic oe, input logic [2:0] ds,
                             input logic rdy, input logic bsy, input logic [1:0] md,
                             input logic pi, input logic rx);
        check_val({tag, ".ie"},   32'(pad_ie),    32'(ie));
        check_val({tag, ".oe"},   32'(pad_oe),    32'(oe));
        check_val({tag, ".ds"},   32'(pad_ds),    32'(ds));
        check_val({tag, ".rdy"},  32'(req_ready), 32'(rdy));
        check_val({tag, ".busy"}, 32'(busy),      32'(bsy));
        check_val({tag, ".mode"}, 32'(mode),      32'(md));
        check_val({tag, ".pi"},   32'(pad_i),     32'(pi));
        check_val({tag, ".rx"},   32'(rx_data),   32'(rx));
        check_val({tag, ".excl"}, 32'(pad_ie & pad_oe), 32'd0);
    endtask

    // Output monitor: pops the entry queued for the edge just taken.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_all(e.tag, e.ie, e.oe, e.ds, e.rdy, e.busy, e.mode, e.pi, e.rx);
        end
    end

    // Apply one cycle of stimulus at the falling edge and queue the post-edge expectation.
    task automatic cyc(input string tag, input logic v, input logic [1:0] dir, input logic [2:0] ds,
                       input logic tx, input logic po,
                       input logic x_ie, input logic x_oe, input logic [2:0] x_ds, input logic x_rdy,
                       input logic x_busy, input logic [1:0] x_mode, input logic x_pi, input logic x_rx);
        exp_t x;
        req_valid = v;
        req_dir   = dir;
        req_ds    = ds;
        tx_data   = tx;
        pad_o     = po;
        x.tag = tag; x.ie = x_ie; x.oe = x_oe; x.ds = x_ds; x.rdy = x_rdy;
        x.busy = x_busy; x.mode = x_mode; x.pi = x_pi; x.rx = x_rx;
        sb.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_dir   = 2'b00;
        req_ds    = 3'd0;
        tx_data   = 1'b0;
        pad_o     = 1'b0;
        #3;
        check_all("reset", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //   tag          v  dir    ds  tx po   ie oe ds  rdy bsy mode  pi rx
        cyc("to_in",      1, 2'b01, 5, 0, 0,   1, 0, 5,  1,  0, 2'b01, 0, 0);
        cyc("idle_in",    0, 2'b00, 0, 0, 0,   1, 0, 5,  1,  0, 2'b01, 0, 0);
        cyc("to_out",     1, 2'b10, 2, 0, 0,   0, 0, 2,  0,  1, 2'b10, 0, 0);
        cyc("turn_a",     0, 2'b00, 0, 1, 0,   0, 0, 2,  0,  1, 2'b10, 0, 0);
        cyc("turn_end",   0, 2'b00, 0, 0, 0,   0, 1, 2,  1,  0, 2'b10, 0, 0);
        cyc("tx0",        0, 2'b00, 0, 0, 0,   0, 1, 2,  1,  0, 2'b10, 0, 0);
        cyc("tx1",        0, 2'b00, 0, 1, 0,   0, 1, 2,  1,  0, 2'b10, 1, 0);
        cyc("tx2",        0, 2'b00, 0, 1, 0,   0, 1, 2,  1,  0, 2'b10, 1, 0);
        cyc("tx3",        0, 2'b00, 0, 0, 0,   0, 1, 2,  1,  0, 2'b10, 0, 0);
        cyc("to_hiz",     1, 2'b00, 1, 1, 0,   0, 0, 1,  1,  0, 2'b00, 0, 0);
        cyc("hiz_to_out", 1, 2'b10, 4, 1, 0,   0, 1, 4,  1,  0, 2'b10, 1, 0);
        cyc("out_to_in",  1, 2'b01, 6, 0, 0,   0, 0, 6,  0,  1, 2'b01, 0, 0);
        cyc("hold_t1",    1, 2'b10, 3, 1, 0,   0, 0, 6,  0,  1, 2'b01, 0, 0);
        cyc("hold_t2",    1, 2'b10, 3, 1, 0,   1, 0, 6,  1,  0, 2'b01, 0, 0);
        cyc("hold_acc",   1, 2'b10, 3, 1, 0,   0, 0, 3,  0,  1, 2'b10, 0, 0);
        cyc("turn_mid",   0, 2'b00, 0, 1, 1,   0, 0, 3,  0,  1, 2'b10, 0, 0);

        // Asynchronous reset in the middle of TURN, checked before any edge.
        #2;
        rst   = 1'b1;
        pad_o = 1'b0;
        #1;
        check_all("rst_mid", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        cyc("post_rst",   1, 2'b01, 5, 0, 0,   1, 0, 5,  1,  0, 2'b01, 0, 0);
        cyc("same_in",    1, 2'b01, 2, 0, 0,   1, 0, 2,  1,  0, 2'b01, 0, 0);
        cyc("rx_e1",      0, 2'b00, 0, 0, 1,   1, 0, 2,  1,  0, 2'b01, 0, 0);
        cyc("rx_e2",      0, 2'b00, 0, 0, 1,   1, 0, 2,  1,  0, 2'b01, 0, 1);
        cyc("dir11",      1, 2'b11, 7, 1, 0,   0, 0, 7,  1,  0, 2'b00, 0, 1);
        cyc("rx_f1",      0, 2'b00, 0, 1, 0,   0, 0, 7,  1,  0, 2'b00, 0, 0);
        cyc("hiz_hold",   0, 2'b00, 0, 1, 1,   0, 0, 7,  1,  0, 2'b00, 0, 0);

        @(negedge clk);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
